tinyalu_cmd_dispatcher: RTL and testbench
=========================================

# tinyalu_cmd_dispatcher

Command front-end placed directly upstream of the TinyALU DUT. Accepts ALU commands over a valid/ready stream, buffers them in a small FIFO, and drives the TinyALU start/operand/op pins one command at a time. It waits for `done` and returns each result on a valid/ready response stream. Testbench components and future integration logic can then stream commands without owning the start/done protocol.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 31: maximum cycles `alu_start` stays high waiting for `alu_done`; 1..255. Used only with the timeout feature.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  upstream command valid.
- `cmd_ready`  out  1  equals `!fifo_full`; no bypass.
- `cmd_a`  in  8  operand A.
- `cmd_b`  in  8  operand B.
- `cmd_op`  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101/110/111 illegal.
- `alu_start`  out  1  TinyALU start, registered.
- `alu_a`, `alu_b`  out  8 each  TinyALU operands, registered.
- `alu_op`  out  3  TinyALU opcode, registered.
- `alu_done`  in  1  TinyALU done.
- `alu_result`  in  16  TinyALU result, valid while `alu_done` is high.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_result`  out  16  captured result.
- `rsp_op`  out  3  opcode of the command that produced the result.
- `rsp_err`  out  1  timeout flag; constant 0 without the macro.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.
- `drop_cnt`  out  8  saturating count of illegal commands dropped.

## Operation
- Push occurs on `cmd_valid && cmd_ready`.
  - Legal opcodes are written to the FIFO.
  - Illegal opcodes (101/110/111) are accepted but not written; `drop_cnt` increments and saturates at 255.
- FSM states: IDLE, ISSUE, NOOP, RESP.
- IDLE, FIFO non-empty:
  - Pop the head entry and load `alu_a`/`alu_b`/`alu_op`.
  - Set `alu_start`=1.
  - Go to NOOP if the opcode is 000, otherwise to ISSUE.
- NOOP: `alu_start` is high for exactly one cycle. No response is produced. Next state is IDLE.
- ISSUE: `alu_start` and the operands are held stable until `alu_done` is sampled high. On that edge:
  - `alu_start` goes to 0.
  - `rsp_result` captures `alu_result` and `rsp_op` captures `alu_op`.
  - `rsp_err` goes to 0 and `rsp_valid` goes to 1.
  - Next state is RESP.
- RESP: `rsp_valid` and the response fields are held until `rsp_valid && rsp_ready`, then the FSM returns to IDLE.
- Only one command is outstanding at a time; results return in command order.
- `alu_done` sampled outside ISSUE is ignored.

## Timing
- Reset values:
  - `alu_start`, `alu_a`, `alu_b`, `alu_op` = 0.
  - `rsp_valid`, `rsp_result`, `rsp_op`, `rsp_err` = 0.
  - `drop_cnt` = 0, `busy` = 0.
  - `cmd_ready` = 1, because the FIFO is empty.
  - FSM is in IDLE.
- Command accepted at edge t into an empty, idle block: `alu_start` rises after edge t+1.
- A command arriving while the FSM is busy is popped on the edge after the FSM re-enters IDLE.
- `rsp_valid` rises on the same edge that samples `alu_done`=1.
- A response handshake at edge r leads to the next `alu_start` after edge r+1, if the FIFO is non-empty.
- FIFO full: `cmd_ready`=0 even if a pop happens in the same cycle. A pop and a push in the same cycle are both performed.
- Pointers wrap modulo `DEPTH`. Occupancy is tracked with a DEPTH+1-value counter.
- Reset mid-operation:
  - `alu_start` drops asynchronously and the FIFO is flushed.
  - Any pending response is discarded.
  - `drop_cnt` clears.

## Configuration
- `TINYALU_DISP_TIMEOUT_EN` defined:
  - ISSUE counts cycles from `alu_start` assertion.
  - If `alu_done` has not been seen after `TIMEOUT` cycles high, `alu_start` drops and the block moves to RESP.
  - The timeout response carries `rsp_err`=1, `rsp_result`=16'h0000 and `rsp_op` = the issued opcode.
  - `alu_done` arriving on the timeout edge wins: a normal response with `rsp_err`=0.
- Not defined: ISSUE waits indefinitely and `rsp_err` is tied to 0.

## Test plan
- Reset, then add A=8'h12 B=8'h34 → `alu_start` high after edge t+1 with `alu_op`=001. DUT `done` → `rsp_result`=16'h0046, `rsp_op`=001, `rsp_err`=0.
- Four back-to-back commands with DEPTH=4 and `rsp_ready`=0 (mul FF×FF, and F0&3C, xor AA^55, add 01+01):
  - `cmd_ready` drops once the FIFO is full.
  - Responses return in order: FE01, 0030, 00FF, 0002.
- Opcodes 110 and 111 interleaved with an add 3+4 → `drop_cnt`=2 and a single response 0007. These commands never reach `alu_op`.
- no_op command → `alu_start` high exactly one cycle and `rsp_valid` stays 0. The following add 5+5 returns 000A.
- Deassert `reset_n` while ISSUE holds a mul with two commands queued → `alu_start` falls immediately and `busy`=0. After release, `rsp_valid`=0 and `cmd_ready`=1.
- With `TINYALU_DISP_TIMEOUT_EN` and TIMEOUT=4, `alu_done` held at 0 → `alu_start` falls after 4 cycles. Response: `rsp_err`=1, `rsp_result`=0000.

Source files
------------

// File: rtl/tinyalu_cmd_dispatcher_if.sv
// tinyalu_cmd_dispatcher_if: command, TinyALU and response signals of the dispatcher
interface tinyalu_cmd_dispatcher_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        alu_start;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  drop_cnt;
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err, busy, drop_cnt
  );
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err, busy, drop_cnt
  );
endinterface

// File: rtl/tinyalu_cmd_dispatcher.sv
// tinyalu_cmd_dispatcher: FIFO-buffered command front-end driving TinyALU start/done, one command at a time.
// Optional start/done watchdog enabled by defining TINYALU_DISP_TIMEOUT_EN.
module tinyalu_cmd_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input logic clk,
  input logic reset_n,
  tinyalu_cmd_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
`ifdef TINYALU_DISP_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, NOOP, RESP} state_t;
  state_t state_q;
  logic [18:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0] drop_q, tmo_q, a_q, b_q;
  logic [2:0] op_q, rsp_op_q;
  logic [15:0] rsp_result_q;
  logic start_q, rsp_valid_q, rsp_err_q;
  logic full, accept, legal, push, pop, tmo_hit;
  logic [18:0] head;
  assign full    = count_q == FULL;
  assign accept  = bus.cmd_valid && !full;
  assign legal   = bus.cmd_op < 3'd5;
  assign push    = accept && legal;
  assign pop     = state_q == IDLE && count_q != '0;
  assign head    = mem_q[rd_ptr_q];
  assign tmo_hit = TMO_EN && tmo_q == TMO_LAST;
  assign bus.cmd_ready  = !full;
  assign bus.alu_start  = start_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = count_q != '0 || state_q != IDLE;
  assign bus.drop_cnt   = drop_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  // done on the watchdog edge wins, so the error flag is simply the absence of done
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      tmo_q        <= '0;
      start_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (accept && !legal && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      case (state_q)
        IDLE: if (pop) begin
          {op_q, a_q, b_q} <= head;
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= head[18:16] == 3'd0 ? NOOP : ISSUE;
        end
        NOOP: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
        ISSUE: if (bus.alu_done || tmo_hit) begin
          start_q      <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= bus.alu_done ? bus.alu_result : 16'h0000;
          rsp_op_q     <= op_q;
          rsp_err_q    <= !bus.alu_done;
          state_q      <= RESP;
        end else tmo_q <= tmo_q + 8'd1;
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tinyalu_cmd_dispatcher.sv
// tb_tinyalu_cmd_dispatcher: directed and randomized checks of the dispatcher against a queue-based model.
// Stimulus and sampling happen on the falling clock edge.
module tb_tinyalu_cmd_dispatcher;
  localparam int TMO = 4;
`ifdef TINYALU_DISP_TIMEOUT_EN
  localparam int KMAX = 1;
`else
  localparam int KMAX = 4;
`endif
  typedef struct {logic [7:0] a; logic [7:0] b; logic [2:0] op;} cmd_t;
  typedef struct {logic [15:0] res; logic [2:0] op;} rsp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int drop_exp = 0;
  cmd_t cmdq[$];
  rsp_t expq[$];
  tinyalu_cmd_dispatcher_if bus();
  tinyalu_cmd_dispatcher #(.DEPTH(4), .TIMEOUT(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    return op == 3'd1 ? 16'(a) + 16'(b) : op == 3'd2 ? {8'h00, a & b} :
           op == 3'd3 ? {8'h00, a ^ b} : op == 3'd4 ? 16'(a) * 16'(b) : 16'h0000;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept", n < 50, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (op >= 3'd5) drop_exp = drop_exp == 255 ? 255 : drop_exp + 1;
    else begin
      cmdq.push_back('{a, b, op});
      if (op != 3'd0) expq.push_back('{alu_fn(a, b, op), op});
    end
  endtask
  task automatic alu_respond(input int lat, output bit was_noop);
    cmd_t c;
    int n = 0;
    was_noop = 1'b0;
    while (!bus.alu_start && n < 50) begin @(negedge clk); n++; end
    check("alu_start_seen", n < 50, 1);
    check("cmd_pending", cmdq.size() > 0, 1);
    if (n >= 50 || cmdq.size() == 0) return;
    c = cmdq.pop_front();
    check("alu_a", bus.alu_a, c.a);
    check("alu_b", bus.alu_b, c.b);
    check("alu_op", bus.alu_op, c.op);
    if (c.op == 3'd0) begin
      was_noop = 1'b1;
      @(negedge clk);
      check("noop_pulse", bus.alu_start, 0);
      check("noop_no_rsp", bus.rsp_valid, 0);
      return;
    end
    repeat (lat) begin
      @(negedge clk);
      check("start_hold", bus.alu_start, 1);
      check("a_hold", bus.alu_a, c.a);
    end
    bus.alu_done = 1'b1;
    bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    @(negedge clk);
    bus.alu_done = 1'b0;
    bus.alu_result = 16'($urandom);
    check("start_drop", bus.alu_start, 0);
    check("rsp_rise", bus.rsp_valid, 1);
  endtask
  task automatic rsp_take(input int dly);
    rsp_t r;
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("rsp_seen", n < 50, 1);
    if (n >= 50) return;
    check("rsp_expected", expq.size() > 0, 1);
    if (expq.size() == 0) return;
    r = expq.pop_front();
    check("rsp_result", bus.rsp_result, r.res);
    check("rsp_op", bus.rsp_op, r.op);
    check("rsp_err", bus.rsp_err, 0);
    repeat (dly) begin
      @(negedge clk);
      check("rsp_hold", bus.rsp_valid, 1);
      check("rsp_hold_res", bus.rsp_result, r.res);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_clear", bus.rsp_valid, 0);
  endtask
  initial begin
    bit nb;
    int k, n, cnt;
    bit anch;
    logic [2:0] rop;
    logic [15:0] tab [5];
    tab[0] = 16'hFE01; tab[1] = 16'h0030; tab[2] = 16'h00FF; tab[3] = 16'h0002; tab[4] = 16'h000F;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_op", bus.rsp_op, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_drop_cnt", bus.drop_cnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    // single add and its issue latency
    send(8'h12, 8'h34, 3'd1);
    check("start_not_yet", bus.alu_start, 0);
    check("busy_queued", bus.busy, 1);
    @(negedge clk);
    check("start_t1", bus.alu_start, 1);
    check("start_t1_op", bus.alu_op, 3'd1);
    alu_respond(0, nb);
    check("add_12_34", bus.rsp_result, 16'h0046);
    rsp_take(0);
    // fill the FIFO while the first response is held
    send(8'hFF, 8'hFF, 3'd4);
    alu_respond(1, nb);
    send(8'hF0, 8'h3C, 3'd2);
    send(8'hAA, 8'h55, 3'd3);
    send(8'h01, 8'h01, 3'd1);
    check("not_full_yet", bus.cmd_ready, 1);
    send(8'h07, 8'h08, 3'd1);
    check("fifo_full", bus.cmd_ready, 0);
    check("fifo_full_busy", bus.busy, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) alu_respond($urandom_range(0, 2), nb);
      check("order_tab", bus.rsp_result, tab[i]);
      rsp_take($urandom_range(0, 2));
      if (i == 0) begin
        alu_respond(0, nb);
        check("ready_after_pop", bus.cmd_ready, 1);
        check("order_tab", bus.rsp_result, tab[1]);
        rsp_take(0);
        i++;
      end
    end
    // illegal opcodes are dropped
    send(8'h09, 8'h09, 3'd6);
    send(8'h03, 8'h04, 3'd1);
    send(8'h01, 8'h02, 3'd7);
    check("drop_cnt_2", bus.drop_cnt, 8'd2);
    check("drop_model", bus.drop_cnt, drop_exp);
    alu_respond(0, nb);
    check("add_3_4", bus.rsp_result, 16'h0007);
    rsp_take(1);
    check("no_extra_cmd", cmdq.size(), 0);
    // no_op then add, plus a stray done in IDLE
    send(8'h11, 8'h22, 3'd0);
    alu_respond(0, nb);
    @(negedge clk);
    check("noop_still_no_rsp", bus.rsp_valid, 0);
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    check("stray_done_rsp", bus.rsp_valid, 0);
    check("stray_done_busy", bus.busy, 0);
    send(8'h05, 8'h05, 3'd1);
    alu_respond(2, nb);
    check("add_5_5", bus.rsp_result, 16'h000A);
    rsp_take(0);
    // randomized batches
    for (int r = 0; r < 12; r++) begin
      k = $urandom_range(1, KMAX);
      anch = 1'b0;
      for (int i = 0; i < k; i++) begin
        rop = 3'($urandom_range(0, 7));
        if (rop == 3'd0 && !anch && i != k - 1) rop = 3'd1;
        if (rop >= 3'd1 && rop <= 3'd4) anch = 1'b1;
        send(8'($urandom), 8'($urandom), rop);
      end
      while (cmdq.size() > 0) begin
        alu_respond($urandom_range(0, 2), nb);
        if (!nb) rsp_take($urandom_range(0, 2));
      end
      check("rand_drop", bus.drop_cnt, drop_exp);
    end
    // drop counter saturation
    for (int i = 0; i < 256; i++) send(8'($urandom), 8'($urandom), 3'($urandom_range(5, 7)));
    check("drop_sat_model", bus.drop_cnt, drop_exp);
    check("drop_sat", bus.drop_cnt, 8'hFF);
    // reset while a mul is issued with two commands queued
    send(8'hFF, 8'h02, 3'd4);
    send(8'h03, 8'h03, 3'd1);
    send(8'h04, 8'h04, 3'd2);
    check("pre_rst_start", bus.alu_start, 1);
    check("pre_rst_op", bus.alu_op, 3'd4);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_start", bus.alu_start, 0);
    check("rst_async_busy", bus.busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cmdq.delete();
    expq.delete();
    drop_exp = 0;
    @(negedge clk);
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_drop", bus.drop_cnt, 0);
    @(negedge clk);
    check("post_rst_flushed", bus.alu_start, 0);
    check("post_rst_idle", bus.busy, 0);
    send(8'h01, 8'h01, 3'd1);
    alu_respond(0, nb);
    rsp_take(0);
`ifdef TINYALU_DISP_TIMEOUT_EN
    send(8'h10, 8'h20, 3'd1);
    n = 0;
    while (!bus.alu_start && n < 50) begin @(negedge clk); n++; end
    cnt = 0;
    while (bus.alu_start && cnt < 20) begin cnt++; @(negedge clk); end
    check("tmo_cycles", cnt, TMO);
    check("tmo_rsp_valid", bus.rsp_valid, 1);
    check("tmo_rsp_err", bus.rsp_err, 1);
    check("tmo_rsp_result", bus.rsp_result, 16'h0000);
    check("tmo_rsp_op", bus.rsp_op, 3'd1);
    void'(cmdq.pop_front());
    void'(expq.pop_front());
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("tmo_rsp_clear", bus.rsp_valid, 0);
    send(8'h21, 8'h03, 3'd4);
    n = 0;
    while (!bus.alu_start && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    bus.alu_done = 1'b1;
    bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    @(negedge clk);
    bus.alu_done = 1'b0;
    check("tmo_edge_done_err", bus.rsp_err, 0);
    check("tmo_edge_done_res", bus.rsp_result, 16'h0063);
    void'(cmdq.pop_front());
    rsp_take(0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
